// File: rtl/riscv_ram.sv
// riscv_ram: word-organised single-port RAM responder for the riscv_cpu memory
// port. It serves one request at a time. Between capturing a request and
// acknowledging it, it inserts WAIT_CYCLES wait states.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES wait states between capture and access (0..15)
//   INIT_FILE   optional preload image name (simulation only)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req_i    request valid, sampled only while idle
//   we_i     1 = write, 0 = read
//   addr_i   byte address
//   wdata_i  write data
//   be_i     byte enables for writes (be_i[0] -> bits 7:0)
//   rdata_o  read data, valid while ack_o = 1 and held until the next read
//   ack_o    one-cycle completion pulse
//   busy_o   high from capture through the ack cycle
//   err_o    address error, qualified by ack_o
//
// Optional feature macro: RAM_ERR_EN
//   When defined, misaligned or out-of-range addresses raise err_o with the
//   ack. Such writes are dropped and such reads return zero. When undefined,
//   err_o stays 0, the low two address bits are dropped and the word index
//   wraps modulo DEPTH.
module riscv_ram #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [AW-1:0] idx;
  logic          addr_err;
  logic          mem_wr;

  assign idx = addr_q[AW+1:2];

`ifdef RAM_ERR_EN
  assign addr_err = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);
`else
  // Byte offset and bits above the index play no part when errors are off.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:AW+2]};
  assign addr_err         = 1'b0;
`endif

  assign mem_wr = (state == S_ACCESS) && we_q && !addr_err;

  // Storage is not reset. Each enabled byte lane is written independently.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Request FSM. ack_o and err_o are registered out of RESP, so the ack cycle
  // is already IDLE and can capture the next request at its closing edge.
  // busy_o is left untouched in RESP, so it stays high through the ack cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_o <= '0;
      ack_o   <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        // capture stage
        S_IDLE: begin
          busy_o <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt     <= WAIT_CYCLES[3:0];
            busy_o  <= 1'b1;
            state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        // wait-state stage: spends exactly WAIT_CYCLES cycles here
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        // array access stage: writes leave rdata_o untouched
        S_ACCESS: begin
          if (!we_q) rdata_o <= addr_err ? 32'h0 : mem[idx];
          state <= S_RESP;
        end
        // response stage
        S_RESP: begin
          ack_o <= 1'b1;
          err_o <= addr_err;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ram.sv
// Testbench for riscv_ram. The main instance uses WAIT_CYCLES = 1 and
// DEPTH = 1024. Two small instances with WAIT_CYCLES = 0 and 15 share the
// same request bus and are used only for latency checks.
module tb_riscv_ram;

  localparam int W     = 1;
  localparam int DEPTH = 1024;
`ifdef RAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic [31:0] rdata;
  logic        ack, busy, err;
  logic [31:0] rdata_unused0, rdata_unused15;
  logic        ack0, busy0, err_unused0;
  logic        ack15, busy15, err_unused15;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  riscv_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .ack_o(ack),
    .busy_o(busy), .err_o(err));

  riscv_ram #(.DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_unused0), .ack_o(ack0),
    .busy_o(busy0), .err_o(err_unused0));

  riscv_ram #(.DEPTH(16), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_unused15), .ack_o(ack15),
    .busy_o(busy15), .err_o(err_unused15));

  typedef struct {
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [12];

  // Behavioural memory model, indexed by word.
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [31:0] a);
    return ERR && ((a % 4 != 0) || (a >= 32'(4 * DEPTH)));
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Called at a negedge and returns at the negedge on which ack was seen.
  task automatic do_txn(input bit t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [3:0] t_be, output int lat, output logic [31:0] rd,
                        output logic er, output bit busy_ok);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    @(posedge clk);
    @(negedge clk);
    // The captured request must not depend on what the bus does afterwards.
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = -1; rd = '0; er = 1'b0; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (ack) begin
        lat = k; rd = rdata; er = err;
        break;
      end
    end
  endtask

  task automatic txn_check(input string nm, input bit t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [3:0] t_be,
                           input logic [31:0] exp_rd, input bit exp_err, input bit chk_rd);
    int lat; logic [31:0] rd; logic er; bit bok;
    do_txn(t_we, t_addr, t_wdata, t_be, lat, rd, er, bok);
    check({nm, "_lat"}, 32'(lat), 32'(2 + W));
    check({nm, "_busy"}, {31'b0, bok}, 32'd1);
    check({nm, "_err"}, {31'b0, er}, {31'b0, exp_err});
    if (chk_rd) check({nm, "_rdata"}, rd, exp_rd);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && !busy0 && !busy15) break;
    end
    check("idle_wait", {29'b0, busy, busy0, busy15}, 32'd0);
  endtask

  initial begin
    int nacks, first_ack, prev_ack, gap_ok;
    int l1, l0, l15;

    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{1'b1, 32'h00,   32'h00000000, 4'hF, 32'h11BB33DD, 1'b0};
    tbl[8]  = '{1'b1, 32'h1002, 32'h12345678, 4'hF, 32'h11BB33DD, ERR};
    tbl[9]  = '{1'b0, 32'h00,   32'h0,        4'h0, ERR ? 32'h0 : 32'h12345678, 1'b0};
    tbl[10] = '{1'b0, 32'h4000, 32'h0,        4'h0, ERR ? 32'h0 : 32'h12345678, ERR};
    tbl[11] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {rdata[31:3], ack, busy, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++)
      txn_check($sformatf("tbl%0d", i), tbl[i].t_we, tbl[i].t_addr, tbl[i].t_wdata,
                tbl[i].t_be, tbl[i].exp_rd, tbl[i].exp_err, 1'b1);

    // Ack latency for WAIT_CYCLES = 0, 1 and 15, all captured at the same edge.
    wait_idle();
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    l1 = -1; l0 = -1; l15 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack && l1 < 0) l1 = k;
      if (ack0 && l0 < 0) l0 = k;
      if (ack15 && l15 < 0) l15 = k;
    end
    check("lat_w1", 32'(l1), 32'd3);
    check("lat_w0", 32'(l0), 32'd2);
    check("lat_w15", 32'(l15), 32'd17);

    // req_i held high for 8 sampling edges: later requests are ignored while busy.
    wait_idle();
    req = 1'b1; we = 1'b0; addr = 32'h0;
    nacks = 0; first_ack = -1; prev_ack = -1; gap_ok = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 8) req = 1'b0;
      if (ack) begin
        nacks++;
        if (first_ack < 0) first_ack = k;
        if (prev_ack >= 0 && (k - prev_ack) != 3 + W) gap_ok = 0;
        prev_ack = k;
      end
    end
    check("busy_req_acks", 32'(nacks), 32'((8 + (3 + W) - 1) / (3 + W)));
    check("busy_req_first", 32'(first_ack), 32'(1 + 2 + W));
    check("busy_req_gap", 32'(gap_ok), 32'd1);

    // Reset during WAIT drops a pending write and never acks it.
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0BADF00D; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #1;
    check("midwait_rst_outputs", {29'b0, ack, busy, err}, 32'd0);
    check("midwait_rst_rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midwait_rst_held", {29'b0, ack, busy, err}, 32'd0);
    reset = 1'b1;
    nacks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) nacks++;
    end
    check("midwait_no_spurious_ack", 32'(nacks), 32'd0);
    check("midwait_idle", {31'b0, busy}, 32'd0);
    txn_check("midwait_readback", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Reset after ACCESS: the write is already committed, but the ack is lost.
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("resp_rst_outputs", {29'b0, ack, busy, err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nacks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack) nacks++;
    end
    check("resp_rst_no_ack", 32'(nacks), 32'd0);
    txn_check("resp_rst_readback", 1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    last_rd = 32'hCAFEF00D;

    // Randomised traffic against the word-array model.
    for (int i = 0; i < 8; i++) begin
      mdl[i] = $urandom;
      txn_check($sformatf("init%0d", i), 1'b1, 32'(4 * i), mdl[i], 4'hF, last_rd, 1'b0, 1'b1);
    end
    for (int n = 0; n < 40; n++) begin
      bit          t_we;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  b;
      int          sel, ix;
      bit          e;
      t_we = 1'($urandom);
      wd   = $urandom;
      b    = 4'($urandom);
      sel  = $urandom_range(0, 3);
      a    = 32'(4 * $urandom_range(0, 7));
      if (sel == 2) a = a + 32'($urandom_range(1, 3));
      if (sel == 3) a = a + 32'h1000 * 32'($urandom_range(1, 3));
      e  = mdl_err(a);
      ix = mdl_idx(a);
      if (t_we) begin
        exp_rd = last_rd;
        if (!e) mdl[ix] = (mdl[ix] & ~be_mask(b)) | (wd & be_mask(b));
      end else begin
        exp_rd  = e ? 32'h0 : mdl[ix];
        last_rd = exp_rd;
      end
      txn_check($sformatf("rnd%0d", n), t_we, a, wd, b, exp_rd, e, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
